apb_master: RTL

APB initiator that converts single-beat commands from an internal requester into APB SETUP/ACCESS transfers on the 8-bit peripheral bus. It is the counterpart to the team's APB responders: it drives psel/penable/pwrite/paddr/pwdata, samples pready/prdata, and returns one response per command. A wait-state timeout keeps a non-responding slave from hanging the requester.

---
 rtl/apb_master.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//
// Converts single-beat commands from an internal requester into APB
// SETUP/ACCESS transfers. There is one response per command. If the slave holds
// pready low for too long, a wait-state timeout aborts the transfer.
//
// Parameters
//   ADDR_W   width of paddr / cmd_addr
//   DATA_W   width of pwdata, prdata, cmd_wdata, rsp_rdata
//   TIMEOUT  maximum number of ACCESS cycles before abort (0 = never abort)
//
// Ports
//   pclk, presetn            clock (rising edge), async active-low reset
//   cmd_valid / cmd_ready    command handshake (accepted only in IDLE)
//   cmd_write, cmd_addr,     command payload, latched on accept
//   cmd_wdata
//   rsp_valid                one-cycle pulse when a transfer finishes
//   rsp_rdata                read data (0 on timeout, unchanged for writes)
//   rsp_timeout              transfer was aborted by the timeout
//   psel, penable, pwrite,   APB request outputs (all registered)
//   paddr, pwdata
//   prdata, pready           APB slave response
// -----------------------------------------------------------------------------
module apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,

  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,

  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  // The counter is wide enough to hold TIMEOUT itself. It only has to reach
  // TIMEOUT-1, and the extra headroom keeps the compare simple.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [1:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  // The counter holds the number of wait edges already seen in this ACCESS
  // phase. When it equals TIMEOUT-1, the current edge is the TIMEOUT-th ACCESS
  // edge.
  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == CNT_LAST);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b1;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      // rsp_valid is a single-cycle pulse unless it is re-asserted below.
      rsp_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            pwrite    <= cmd_write;
            paddr     <= cmd_addr;
            pwdata    <= cmd_wdata;
            psel      <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= S_SETUP;
          end
        end

        S_SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= '0;
          state    <= S_ACCESS;
        end

        S_ACCESS: begin
          // pready is checked first, so a completion on the timeout edge wins.
          if (pready) begin
            if (!pwrite) begin
              rsp_rdata <= prdata;
            end
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            cmd_ready   <= 1'b1;
            state       <= S_IDLE;
          end else if (timeout_hit) begin
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            cmd_ready   <= 1'b1;
            state       <= S_IDLE;
          end else if (TIMEOUT > 0) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: begin
          // An unreachable encoding returns the bus to a quiet idle state.
          psel      <= 1'b0;
          penable   <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
